// File: rtl/stopwatch_bcd_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_bcd_core: centisecond prescaler and MM:SS.cc BCD counter     |
// | with run/pause, lap freeze and clear.            Revision: 1.0         |
// +----------------------------------------------------------------------+
module stopwatch_bcd_core #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART_STOP,
    input  logic       iLAP,
    input  logic       iCLR,
    output logic [3:0] oDIG0,
    output logic [3:0] oDIG1,
    output logic [3:0] oDIG2,
    output logic [3:0] oDIG3,
    output logic [3:0] oDIG4,
    output logic [3:0] oDIG5,
    output logic       oRUN,
    output logic       oLAP,
    output logic       oWRAP
);

    localparam int C_DIV   = CLK_HZ / TICK_HZ;
    localparam int C_PRE_W = $clog2(C_DIV);
    localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(C_DIV - 1);
    localparam logic [C_PRE_W-1:0] C_PRE_ONE = C_PRE_W'(1);
    // Per-digit wrap limits, digit 5 (minutes tens) down to digit 0.
    localparam logic [5:0][3:0] C_LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_PRE_W-1:0]   r_pre;
    logic [C_PRE_W-1:0]   w_pre_nxt;
    logic [5:0][3:0]      r_cnt;
    logic [5:0][3:0]      w_cnt_nxt;
    logic [5:0][3:0]      w_cnt_inc;
    logic [5:0][3:0]      r_snap;
    logic [5:0][3:0]      w_snap_nxt;
    logic                 r_lap;
    logic                 w_lap_nxt;
    logic                 r_run;
    logic                 r_wrap;
    logic                 w_roll;
    logic                 w_tick;
    logic                 w_clear;
    logic [5:0][3:0]      w_disp;

    // BCD ripple increment; >= keeps any out-of-range code from persisting.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        w_cnt_inc = r_cnt;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r_cnt[i] >= C_LIM[i]) begin
                    w_cnt_inc[i] = 4'd0;
                end else begin
                    w_cnt_inc[i] = r_cnt[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
        w_roll = carry;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_cnt_nxt   = r_cnt;
        w_snap_nxt  = r_snap;
        w_lap_nxt   = r_lap;
        w_tick      = (r_state == S_RUN) && (r_pre == C_PRE_MAX);
        w_clear     = (r_state == S_PAUSE) && iCLR;

        case (r_state)
            S_IDLE:  if (iSTART_STOP) w_state_nxt = S_RUN;
            S_RUN:   if (iSTART_STOP) w_state_nxt = S_PAUSE;
            S_PAUSE: begin
                if (iCLR)             w_state_nxt = S_IDLE;
                else if (iSTART_STOP) w_state_nxt = S_RUN;
            end
            default:                  w_state_nxt = S_IDLE;
        endcase

        // Prescaler holds through PAUSE so a resumed interval keeps its phase.
        if (w_clear || (r_state == S_IDLE)) begin
            w_pre_nxt = '0;
        end else if (r_state == S_RUN) begin
            w_pre_nxt = w_tick ? '0 : r_pre + C_PRE_ONE;
        end

        if (w_clear) begin
            w_cnt_nxt = '0;
        end else if (w_tick) begin
            w_cnt_nxt = w_cnt_inc;
        end

        // Snapshot captures the post-tick value when lap and tick coincide.
        if (w_clear) begin
            w_lap_nxt  = 1'b0;
            w_snap_nxt = '0;
        end else if (iLAP) begin
            if (r_lap && (r_state != S_IDLE)) begin
                w_lap_nxt = 1'b0;
            end else if (!r_lap && (r_state == S_RUN)) begin
                w_lap_nxt  = 1'b1;
                w_snap_nxt = w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_snap  <= '0;
            r_lap   <= 1'b0;
            r_run   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_cnt   <= w_cnt_nxt;
            r_snap  <= w_snap_nxt;
            r_lap   <= w_lap_nxt;
            r_run   <= (w_state_nxt == S_RUN);
            r_wrap  <= w_tick && w_roll;
        end
    end

    assign w_disp = r_lap ? r_snap : r_cnt;
    assign oDIG0  = w_disp[0];
    assign oDIG1  = w_disp[1];
    assign oDIG2  = w_disp[2];
    assign oDIG3  = w_disp[3];
    assign oDIG4  = w_disp[4];
    assign oDIG5  = w_disp[5];
    assign oRUN   = r_run;
    assign oLAP   = r_lap;
    assign oWRAP  = r_wrap;

endmodule
`default_nettype wire

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
- Timing core of the FPGA stopwatch. It divides the system clock down to a 1/100 s tick and counts elapsed time as six BCD digits, MM:SS.cc.
- Provides start/stop, lap-freeze and clear control.
- Sits directly upstream of the per-digit 7-segment decoders: each 4-bit digit output drives one decoder input.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (one centisecond).
- DIV = CLK_HZ/TICK_HZ is derived, not overridable. Legal configurations require DIV >= 2 and an integer result.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iSTART_STOP  in  1  single-cycle pulse; toggles run/pause.
- iLAP  in  1  single-cycle pulse; freezes or releases the displayed value.
- iCLR  in  1  single-cycle pulse; zeroes the count when not running.
- oDIG0  out  4  centiseconds ones (0-9).
- oDIG1  out  4  centiseconds tens (0-9).
- oDIG2  out  4  seconds ones (0-9).
- oDIG3  out  4  seconds tens (0-5).
- oDIG4  out  4  minutes ones (0-9).
- oDIG5  out  4  minutes tens (0-5).
- oRUN  out  1  high while counting.
- oLAP  out  1  high while the display is frozen.
- oWRAP  out  1  one-cycle pulse when the count rolls from 59:59.99 to 00:00.00.

Behaviour:
- Reset (iRST=1 at an edge), regardless of state:
  - State=IDLE; prescaler=0; live count=0; lap snapshot=0.
  - oDIG0..5=0, oRUN=0, oLAP=0, oWRAP=0.
  - Reset overrides every other input in the same cycle.
- States:
  - IDLE: stopped, count zero.
  - RUN: counting.
  - PAUSE: stopped, count held.
- Transitions:
  - IDLE + iSTART_STOP -> RUN.
  - RUN + iSTART_STOP -> PAUSE.
  - PAUSE + iSTART_STOP -> RUN.
  - PAUSE + iCLR -> IDLE. Clears count, prescaler and lap hold.
  - If iCLR and iSTART_STOP coincide in PAUSE, iCLR wins: next state is IDLE.
  - iCLR in RUN is ignored.
  - iCLR in IDLE is a no-op.
- Prescaler:
  - Counts 0..DIV-1 only in RUN; holds its value in PAUSE, so a resumed interval is not truncated.
  - tick = (state==RUN) && (prescaler==DIV-1); prescaler then returns to 0.
  - The first tick after IDLE->RUN occurs DIV cycles after the start edge.
- Count on tick, as a BCD ripple:
  - DIG0 wraps 9->0 and carries into DIG1.
  - DIG1 wraps 9->0, carry to DIG2.
  - DIG2 wraps 9->0, carry to DIG3.
  - DIG3 wraps 5->0, carry to DIG4.
  - DIG4 wraps 9->0, carry to DIG5.
  - DIG5 wraps 5->0 and asserts oWRAP for the cycle after that edge.
  - The count keeps running after a wrap.
  - No digit ever holds a value above its wrap limit; there are no non-BCD codes.
- Lap:
  - iLAP in RUN with oLAP=0: snapshot <= the live count at that edge, including the increment if a tick occurs in the same cycle. oLAP <= 1.
  - iLAP in RUN or PAUSE with oLAP=1: oLAP <= 0, and the display returns to the live count.
  - iLAP in IDLE is ignored.
  - iLAP in PAUSE with oLAP=0 is ignored.
  - The live count continues to advance while oLAP=1.
- Outputs:
  - oDIGn = oLAP ? snapshot digit : live digit. This is a combinational mux of registers, so a new count is visible in the cycle after its tick edge.
  - oRUN = (state==RUN), registered.
- Simultaneous inputs:
  - iSTART_STOP + iLAP in RUN: both take effect. State becomes PAUSE and the lap snapshot is taken or released.
  - A tick coinciding with iSTART_STOP (RUN->PAUSE): the tick increment is applied.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset then release; 50 idle cycles -> all oDIG=0, oRUN=0, oLAP=0, oWRAP=0.
- Pulse iSTART_STOP at cycle 0; run 250 cycles -> oDIG1:oDIG0=2:5 and oRUN=1. The first DIG0 change is 0->1 exactly 10 cycles after the start edge.
- Pause mid-interval at prescaler=4; wait 100 cycles; resume -> digits are unchanged during the pause, and the next increment comes 6 cycles after resume.
- Run to 00:09.99 and tick once -> 00:10.00 (DIG2=0, DIG3=1). Preload via run to 59:59.99 and tick -> 00:00.00 with oWRAP high for exactly 1 cycle.
- In RUN at 00:01.23, pulse iLAP -> display holds 01.23 while the live count advances. Pulse iLAP at live 00:03.00 -> display shows 03.00 and oLAP=0.
- In PAUSE, pulse iCLR and iSTART_STOP together -> IDLE, all digits 0, oRUN=0. iCLR in RUN -> no change. Assert iRST mid-count -> all outputs 0 on the next cycle.
